// File: rtl/ahb_apb_pkg.sv
// Shared encodings and constants for the AHB-to-APB bridge.
// Imported by the AHB front end, the address decoder and the bench.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [31:0] P0_BASE  = 32'h8000_0000;
    localparam logic [31:0] P0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] P1_BASE  = 32'h8400_0000;
    localparam logic [31:0] P1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] P2_BASE  = 32'h8800_0000;
    localparam logic [31:0] P2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_P0   = 3'b001;
    localparam logic [2:0] SEL_P1   = 3'b010;
    localparam logic [2:0] SEL_P2   = 3'b100;

    typedef enum logic [1:0] {
        OKAY = 2'b00,
        ERR1 = 2'b01,
        ERR2 = 2'b10
    } err_state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// Combinational peripheral select and alignment check.
// Pure function of the address-phase Haddr and Hsize.
module ahb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [2:0]        Hsize,
    output logic [2:0]        tempselx,
    output logic              misaligned
);

    always_comb begin
        tempselx = SEL_NONE;
        if (Haddr >= ADDR_W'(P0_BASE) && Haddr <= ADDR_W'(P0_LIMIT))
            tempselx = SEL_P0;
        else if (Haddr >= ADDR_W'(P1_BASE) && Haddr <= ADDR_W'(P1_LIMIT))
            tempselx = SEL_P1;
        else if (Haddr >= ADDR_W'(P2_BASE) && Haddr <= ADDR_W'(P2_LIMIT))
            tempselx = SEL_P2;
    end

    always_comb begin
        misaligned = 1'b0;
        if (Hsize == HSIZE_HALF)
            misaligned = Haddr[0];
        else if (Hsize == HSIZE_WORD)
            misaligned = (Haddr[1:0] != 2'b00);
        else if (Hsize > HSIZE_WORD)
            misaligned = 1'b1;
    end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB front end of the AHB-to-APB bridge: pipelining, select decode
// and two-cycle ERROR response for unmapped or misaligned transfers.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Hwrite,
    input  logic                Hreadyin,
    input  logic [1:0]          Htrans,
    input  logic [2:0]          Hsize,
    input  logic [ADDR_W-1:0]   Haddr,
    input  logic [DATA_W-1:0]   Hwdata,
    input  logic                Hreadyout_fsm,
    output logic                valid,
    output logic [ADDR_W-1:0]   Haddr1,
    output logic [ADDR_W-1:0]   Haddr2,
    output logic [DATA_W-1:0]   Hwdata1,
    output logic [DATA_W-1:0]   Hwdata2,
    output logic                Hwritereg,
    output logic [2:0]          tempselx,
    output logic                Hreadyout,
    output logic                Hresp,
    output logic [ERRCNT_W-1:0] err_count
);

    err_state_e state, state_nxt;
    logic       active;
    logic       misaligned;
    logic       bad;

    ahb_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
        .Haddr      (Haddr),
        .Hsize      (Hsize),
        .tempselx   (tempselx),
        .misaligned (misaligned)
    );

    assign active = Hreadyin &
                    ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ));
    assign bad    = active & ((tempselx == SEL_NONE) | misaligned);
    assign valid  = active & ~bad & (state == OKAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Haddr1    <= '0;
            Haddr2    <= '0;
            Hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1    <= Haddr;
            Haddr2    <= Haddr1;
            Hwritereg <= Hwrite;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Hwdata1 <= '0;
            Hwdata2 <= '0;
        end else begin
            Hwdata1 <= Hwdata;
            Hwdata2 <= Hwdata1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= OKAY;
        else     state <= state_nxt;
    end

    // ERR1 stalls the master, ERR2 completes the ERROR response
    always_comb begin
        state_nxt = state;
        Hreadyout = Hreadyout_fsm;
        unique case (state)
            OKAY: begin
                if (bad) state_nxt = ERR1;
            end
            ERR1: begin
                state_nxt = ERR2;
                Hreadyout = 1'b0;
            end
            ERR2: begin
                state_nxt = bad ? ERR1 : OKAY;
                Hreadyout = 1'b1;
            end
            default: begin
                state_nxt = OKAY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) Hresp <= 1'b0;
        else     Hresp <= (state_nxt != OKAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (state_nxt == ERR1 && state != ERR1 && err_count != '1)
            err_count <= err_count + 1'b1;
    end

endmodule
